// File: rtl/config_reg_initiator.sv
// Command front-end for a config register block: single reads, and writes that are
// read back and retried up to MAX_RETRY times before reporting an error.
module config_reg_initiator #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              cfg_write,
    output logic [ADDR_W-1:0] cfg_address,
    output logic [DATA_W-1:0] cfg_data_in,
    input  logic [DATA_W-1:0] cfg_data_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned RETRY_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_WAIT,
        CHECK,
        RSP
    } state_t;

    state_t              state_q, state_d;
    logic                rw_q, rw_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   data_d;
    logic [DATA_W-1:0]   rsp_data_d;
    logic                rsp_err_d;

    // Next state plus next value of every registered output.
    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        retry_d    = retry_q;
        addr_d     = cfg_address;
        data_d     = cfg_data_in;
        rsp_data_d = rsp_data;
        rsp_err_d  = rsp_err;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    rw_d    = req_rw;
                    addr_d  = req_addr;
                    data_d  = req_data;
                    retry_d = '0;
                    state_d = req_rw ? WR : RD_WAIT;
                end
            end
            WR:      state_d = RD_WAIT;
            RD_WAIT: state_d = CHECK;
            CHECK: begin
                rsp_data_d = cfg_data_out;
                if (!rw_q || (cfg_data_out == cfg_data_in)) begin
                    rsp_err_d = 1'b0;
                    state_d   = RSP;
                end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = WR;
                end else begin
                    rsp_err_d = 1'b1;
                    state_d   = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rw_q        <= 1'b0;
            retry_q     <= '0;
            cfg_write   <= 1'b0;
            cfg_address <= '0;
            cfg_data_in <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            req_ready   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            retry_q     <= retry_d;
            cfg_write   <= (state_d == WR);
            cfg_address <= addr_d;
            cfg_data_in <= data_d;
            rsp_valid   <= (state_d == RSP);
            rsp_data    <= rsp_data_d;
            rsp_err     <= rsp_err_d;
            busy        <= (state_d != IDLE);
            req_ready   <= (state_d == IDLE);
        end
    end

endmodule

// File: tb/tb_config_reg_initiator.sv
// Directed bench for config_reg_initiator against a small register-block model.
module tb_config_reg_initiator;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              cfg_write;
    logic [ADDR_W-1:0] cfg_address;
    logic [DATA_W-1:0] cfg_data_in;
    logic [DATA_W-1:0] cfg_data_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;

    int errors = 0;
    int checks = 0;

    config_reg_initiator #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_RETRY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_data(req_data),
        .cfg_write(cfg_write), .cfg_address(cfg_address), .cfg_data_in(cfg_data_in),
        .cfg_data_out(cfg_data_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Register block model, optionally stuck at a fixed readback value.
    logic [DATA_W-1:0] mem [8];
    logic              stuck;
    logic [DATA_W-1:0] stuck_val;
    always @(posedge clk) if (cfg_write) mem[cfg_address] <= cfg_data_in;
    assign cfg_data_out = stuck ? stuck_val : mem[cfg_address];

    int pulse_total = 0;
    int acc_total   = 0;
    int rsp_total   = 0;
    logic [DATA_W:0] rsp_q [$];
    always @(posedge clk) begin
        if (cfg_write) pulse_total <= pulse_total + 1;
        if (req_valid && req_ready) acc_total <= acc_total + 1;
        if (rsp_valid && rsp_ready) begin
            rsp_total <= rsp_total + 1;
            rsp_q.push_back({rsp_err, rsp_data});
        end
    end

    // Presents one request at a negedge, returns at the negedge after the accept edge.
    task automatic send_req(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = a;
        req_data  = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_rw    = ~rw;
        req_addr  = ~a;
        req_data  = ~d;
    endtask

    // Latency counts clock edges from (and including) the accept edge.
    task automatic wait_rsp(output int lat, output bit rdy_seen);
        lat      = 1;
        rdy_seen = 1'b0;
        while (!rsp_valid && lat < 60) begin
            if (req_ready) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (req_ready) rdy_seen = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cfg_write, cfg_address, cfg_data_in} !== '0) begin
            errors++; $display("FAIL reset_cfg: got %b/%h/%h want 0/0/0", cfg_write, cfg_address, cfg_data_in);
        end
        checks++;
        if ({rsp_valid, rsp_data, rsp_err, busy, req_ready} !== '0) begin
            errors++; $display("FAIL reset_rsp: got v=%b d=%h e=%b busy=%b rdy=%b want all 0", rsp_valid, rsp_data, rsp_err, busy, req_ready);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_release_rdy: got %b want 0", req_ready);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_first_edge: got rdy=%b busy=%b want 1/0", req_ready, busy);
        end
    endtask

    task automatic test_write();
        int p0, lat;
        bit rdy;
        rsp_ready = 1'b1;
        p0 = pulse_total;
        send_req(1'b1, 3'd4, 16'h2025);
        checks++;
        if (cfg_write !== 1'b1 || cfg_address !== 3'd4 || cfg_data_in !== 16'h2025) begin
            errors++; $display("FAIL write_wr_state: got w=%b a=%h d=%h want 1/4/2025", cfg_write, cfg_address, cfg_data_in);
        end
        wait_rsp(lat, rdy);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL write_latency: got %0d want 4", lat); end
        checks++;
        if (rsp_data !== 16'h2025 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL write_rsp: got d=%h e=%b want 2025/0", rsp_data, rsp_err);
        end
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL write_ready_busy: got req_ready high while busy, want low"); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL write_idle: got v=%b rdy=%b busy=%b want 0/1/0", rsp_valid, req_ready, busy);
        end
        checks++;
        if (pulse_total - p0 !== 1) begin errors++; $display("FAIL write_pulses: got %0d want 1", pulse_total - p0); end
        checks++;
        if (cfg_address !== 3'd4 || cfg_data_in !== 16'h2025) begin
            errors++; $display("FAIL write_hold_idle: got a=%h d=%h want 4/2025", cfg_address, cfg_data_in);
        end
    endtask

    task automatic test_read();
        int p0, lat;
        bit rdy;
        rsp_ready = 1'b1;
        p0 = pulse_total;
        send_req(1'b0, 3'd4, 16'hFFFF);
        wait_rsp(lat, rdy);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL read_latency: got %0d want 3", lat); end
        checks++;
        if (rsp_data !== 16'h2025 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL read_rsp: got d=%h e=%b want 2025/0", rsp_data, rsp_err);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (pulse_total - p0 !== 0) begin errors++; $display("FAIL read_pulses: got %0d want 0", pulse_total - p0); end
    endtask

    task automatic test_retry();
        int p0, lat;
        bit rdy;
        rsp_ready = 1'b1;
        stuck     = 1'b1;
        stuck_val = 16'hA0CD;
        p0 = pulse_total;
        send_req(1'b1, 3'd4, 16'h2025);
        wait_rsp(lat, rdy);
        checks++;
        if (lat !== 10) begin errors++; $display("FAIL retry_latency: got %0d want 10", lat); end
        checks++;
        if (rsp_data !== 16'hA0CD || rsp_err !== 1'b1) begin
            errors++; $display("FAIL retry_rsp: got d=%h e=%b want a0cd/1", rsp_data, rsp_err);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (pulse_total - p0 !== 3) begin errors++; $display("FAIL retry_pulses: got %0d want 3", pulse_total - p0); end
        stuck = 1'b0;
    endtask

    task automatic test_hold();
        int lat;
        bit rdy, bad;
        rsp_ready = 1'b0;
        bad = 1'b0;
        send_req(1'b0, 3'd4, 16'h0000);
        wait_rsp(lat, rdy);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h2025 || rsp_err !== 1'b0 || req_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL hold_stable: got v=%b d=%h rdy=%b want 1/2025/0 throughout", rsp_valid, rsp_data, req_ready);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_release: got v=%b rdy=%b busy=%b want 0/1/0", rsp_valid, req_ready, busy);
        end
    endtask

    task automatic test_abort();
        int p0, r0, lat;
        bit rdy;
        rsp_ready = 1'b1;
        p0 = pulse_total;
        r0 = rsp_total;
        send_req(1'b1, 3'd4, 16'h8000);
        checks++;
        if (cfg_write !== 1'b1) begin errors++; $display("FAIL abort_in_wr: got %b want 1", cfg_write); end
        reset = 1'b0;
        #1;
        checks++;
        if ({cfg_write, cfg_address, cfg_data_in, rsp_valid, rsp_data, rsp_err, busy, req_ready} !== '0) begin
            errors++; $display("FAIL abort_outputs: got w=%b a=%h d=%h v=%b busy=%b rdy=%b want all 0",
                               cfg_write, cfg_address, cfg_data_in, rsp_valid, busy, req_ready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (rsp_total - r0 !== 0 || pulse_total - p0 !== 0) begin
            errors++; $display("FAIL abort_quiet: got rsp=%0d pulses=%0d want 0/0", rsp_total - r0, pulse_total - p0);
        end
        send_req(1'b0, 3'd4, 16'h0000);
        wait_rsp(lat, rdy);
        checks++;
        if (lat !== 3 || rsp_data !== 16'h2025 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL abort_next_req: got lat=%0d d=%h e=%b want 3/2025/0", lat, rsp_data, rsp_err);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic              rw   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [ADDR_W-1:0] addr [5] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd1};
        logic [DATA_W-1:0] wdat [5] = '{16'h1111, 16'h0000, 16'hBEEF, 16'h0000, 16'h5A5A};
        logic [DATA_W-1:0] exp  [5] = '{16'h1111, 16'h1111, 16'hBEEF, 16'hBEEF, 16'h5A5A};
        int a0, r0, qb, n;
        rsp_ready = 1'b1;
        a0 = acc_total;
        r0 = rsp_total;
        qb = rsp_q.size();
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_rw   = rw[i];
            req_addr = addr[i];
            req_data = wdat[i];
            n = 0;
            while (!req_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        n = 0;
        while (rsp_total - r0 < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (acc_total - a0 !== 5 || rsp_total - r0 !== 5) begin
            errors++; $display("FAIL b2b_counts: got acc=%0d rsp=%0d want 5/5", acc_total - a0, rsp_total - r0);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (qb + i >= rsp_q.size()) begin
                errors++; $display("FAIL b2b_rsp%0d: got none want %h", i, exp[i]);
            end else if (rsp_q[qb + i] !== {1'b0, exp[i]}) begin
                errors++; $display("FAIL b2b_rsp%0d: got %h want %h", i, rsp_q[qb + i], {1'b0, exp[i]});
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        stuck     = 1'b0;
        stuck_val = '0;
        test_reset();
        test_write();
        test_read();
        test_retry();
        test_hold();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/config_reg_initiator.md
CONFIG_REG_INITIATOR -- requirements
Module: config_reg_initiator

Interface
REQ-001 SHALL have parameter DATA_W, default 16, config word width.
REQ-002 SHALL have parameter ADDR_W, default 3, config register address width.
REQ-003 SHALL have parameter MAX_RETRY, default 2, extra write attempts after a failed readback, range 0..7.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  command request.
REQ-007 SHALL have port req_ready  output  1  command accept; high only in IDLE.
REQ-008 SHALL have port req_rw  input  1  1 = write-and-verify, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_W  target register address.
REQ-010 SHALL have port req_data  input  DATA_W  write data; ignored for reads.
REQ-011 SHALL have port cfg_write  output  1  write strobe to the config register block.
REQ-012 SHALL have port cfg_address  output  ADDR_W  address to the config register block.
REQ-013 SHALL have port cfg_data_in  output  DATA_W  write data to the config register block.
REQ-014 SHALL have port cfg_data_out  input  DATA_W  readback data from the config register block.
REQ-015 SHALL have port rsp_valid  output  1  response available.
REQ-016 SHALL have port rsp_ready  input  1  response consumed.
REQ-017 SHALL have port rsp_data  output  DATA_W  readback value.
REQ-018 SHALL have port rsp_err  output  1  verify failure after all retries; always 0 for reads.
REQ-019 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-020 SHALL implement states IDLE, WR, RD_WAIT, CHECK, RSP.
REQ-021 Accept: in IDLE, req_valid && req_ready SHALL latch req_rw, req_addr and req_data, clear the retry counter, and go to WR if req_rw=1, otherwise RD_WAIT.
REQ-022 WR SHALL last exactly 1 cycle with cfg_write=1, cfg_address=latched address and cfg_data_in=latched data, then go to RD_WAIT.
REQ-023 cfg_write SHALL be 0 in every state except WR.
REQ-024 RD_WAIT SHALL last exactly 1 cycle with cfg_write=0 and cfg_address held, then go to CHECK.
REQ-025 CHECK SHALL capture cfg_data_out into rsp_data.
REQ-026 In CHECK, a read SHALL go to RSP with rsp_err=0.
REQ-027 In CHECK, a write whose cfg_data_out equals the latched data SHALL go to RSP with rsp_err=0.
REQ-028 In CHECK, a write mismatch with retry count < MAX_RETRY SHALL increment the counter and return to WR.
REQ-029 In CHECK, a write mismatch with retry count = MAX_RETRY SHALL go to RSP with rsp_err=1.
REQ-030 Latency with accept at cycle 0: write-verify with no retry SHALL raise rsp_valid at cycle 4; a read SHALL raise it at cycle 3; each retry SHALL add 3 cycles.
REQ-031 In RSP, rsp_valid=1 and rsp_data/rsp_err SHALL stay stable until rsp_ready=1; the state SHALL then return to IDLE with rsp_valid=0 the next cycle.
REQ-032 req_ready SHALL be 0 from the accept cycle until back in IDLE; a new request SHALL NOT be accepted in the same cycle the response is consumed.
REQ-033 cfg_address and cfg_data_in SHALL hold the last latched values in all states, including IDLE.
REQ-034 Changes to req_* after accept SHALL have no effect on the operation in progress.

Reset
REQ-035 reset=0 SHALL immediately force IDLE from any state, including mid-operation, and clear the retry counter.
REQ-036 While reset=0, outputs SHALL be: cfg_write=0, cfg_address=0, cfg_data_in=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, req_ready=0.
REQ-037 req_ready SHALL rise on the first clock edge after reset deasserts.
REQ-038 An aborted operation SHALL produce no response and no further cfg_write pulse.

Verification
REQ-039 Write 0x2025 to addr 4 against a correct register model, rsp_ready=1 -> exactly one cfg_write pulse; rsp_valid at cycle 4; rsp_data=0x2025; rsp_err=0.
REQ-040 Read addr 4 after REQ-039 -> no cfg_write pulse; rsp_valid at cycle 3; rsp_data=0x2025; rsp_err=0.
REQ-041 Write 0x2025 while the model returns stuck 0xA0CD, MAX_RETRY=2 -> 3 cfg_write pulses; rsp_valid at cycle 10; rsp_data=0xA0CD; rsp_err=1.
REQ-042 Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rsp_data held stable and req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
REQ-043 Assert reset during WR of write 0x8000 to addr 4 -> cfg_write drops immediately; all outputs at reset values; no response; the next request completes normally.
REQ-044 Hold req_valid=1 continuously with back-to-back commands -> each accepted only when req_ready=1; no command lost or duplicated.
